// File: rtl/rv32i_ifetch_if.sv
// Fetch-stage bundle: instruction memory bus, redirect input and decoder handshake.
interface rv32i_ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr, instr_pc, instr_valid,
        input  instr_ready,
        output fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr, instr_pc, instr_valid,
        output instr_ready,
        input  fetch_fault
    );
endinterface

// File: rtl/rv32i_ifetch.sv
// RV32I fetch stage: PC, single-outstanding imem fetch, {pc,word} FIFO to decode.
// RV32I_IFETCH_MISALIGN_TRAP_EN: misaligned redirect sets sticky fetch_fault and halts fetch.
module rv32i_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic [4:0]          LOGISIM_CLOCK_TREE_0,
    input  logic                rst_n,
    rv32i_ifetch_if.master      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    logic          clk;
    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [31:0]   word_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fault_q;
    logic [31:0]   rpc;
    logic          misalign;
    logic          valid;
    logic          push;
    logic          pop;

    assign clk = LOGISIM_CLOCK_TREE_0[4];
    assign rpc = {bus.redirect_pc[31:2], 2'b00};

`ifdef RV32I_IFETCH_MISALIGN_TRAP_EN
    assign misalign = bus.redirect_pc[1:0] != 2'b00;
    wire unused_ok = &{1'b0, LOGISIM_CLOCK_TREE_0[3:0]};
`else
    assign misalign = 1'b0;
    wire unused_ok = &{1'b0, LOGISIM_CLOCK_TREE_0[3:0],
                       bus.redirect_pc[1:0]};
`endif

    assign valid = count != '0;
    assign push  = state == WAIT && bus.imem_rvalid;
    assign pop   = valid && bus.instr_ready;

    assign bus.imem_req    = rst_n && state == IDLE && !fault_q
                             && count < CW'(FIFO_DEPTH);
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? word_q[rd_ptr] : '0;
    assign bus.instr_pc    = valid ? pc_q[rd_ptr] : '0;
    assign bus.fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fault_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else if (bus.redirect) begin
            // Flush wins; any granted or pending response becomes stale.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= rpc;
            if (misalign)
                fault_q <= 1'b1;
            unique case (state)
                IDLE: if (bus.imem_req && bus.imem_gnt) state <= DROP;
                WAIT: state <= bus.imem_rvalid ? IDLE : DROP;
                DROP: if (bus.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: if (bus.imem_req && bus.imem_gnt) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd4;
                    state       <= WAIT;
                end
                WAIT: if (bus.imem_rvalid) state <= IDLE;
                DROP: if (bus.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) begin
                pc_q[wr_ptr]   <= inflight_pc;
                word_q[wr_ptr] <= bus.imem_rdata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
